// File: rtl/openram_tc_pkg.sv
// Shared definitions for the OpenRAM test-chip controller: packet layout,
// chip ids and the strobe/capture sequencer states.
package openram_tc_pkg;

  localparam int PKT_W   = 112;
  localparam int DATA_W  = 32;
  localparam int NSRAM   = 5;
  localparam int CHIP_W  = 4;
  localparam int ADDR_W  = 16;
  localparam int WMASK_W = 4;

  // Bit offsets of the packet fields, LSB of each field.
  localparam int CHIP_LSB   = 108;
  localparam int ADDR0_LSB  = 92;
  localparam int DIN0_LSB   = 60;
  localparam int CSB0_BIT   = 59;
  localparam int WEB0_BIT   = 58;
  localparam int WMASK0_LSB = 54;
  localparam int ADDR1_LSB  = 38;
  localparam int DIN1_LSB   = 6;
  localparam int CSB1_BIT   = 5;
  localparam int WEB1_BIT   = 4;
  localparam int WMASK1_LSB = 0;

  localparam logic [CHIP_W-1:0] CHIP_SRAM0 = 4'd0;
  localparam logic [CHIP_W-1:0] CHIP_SRAM1 = 4'd1;
  localparam logic [CHIP_W-1:0] CHIP_SRAM2 = 4'd2;
  localparam logic [CHIP_W-1:0] CHIP_SRAM3 = 4'd3;
  localparam logic [CHIP_W-1:0] CHIP_SRAM4 = 4'd4;

  typedef struct packed {
    logic [CHIP_W-1:0]  chip;
    logic [ADDR_W-1:0]  addr0;
    logic [DATA_W-1:0]  din0;
    logic               csb0;
    logic               web0;
    logic [WMASK_W-1:0] wmask0;
    logic [ADDR_W-1:0]  addr1;
    logic [DATA_W-1:0]  din1;
    logic               csb1;
    logic               web1;
    logic [WMASK_W-1:0] wmask1;
  } pkt_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLK_HI = 2'd1,
    ST_CLK_LO = 2'd2,
    ST_CAPT   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/openram_tc_seq.sv
// Strobe/capture sequencer: one clock pulse to the selected macro, a settle
// cycle, then a capture cycle, then back to IDLE.
module openram_tc_seq
  import openram_tc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [NSRAM-1:0] chip_sel,
  output logic [NSRAM-1:0] sram_clk,
  output logic             capt,
  output logic             idle,
  output seq_state_e       state
);

  seq_state_e state_next;

  // go is a level sampled only in IDLE; there is no ready, every op takes
  // exactly four cycles and go held high chains ops back to back.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:   if (go) state_next = ST_CLK_HI;
      ST_CLK_HI: state_next = ST_CLK_LO;
      ST_CLK_LO: state_next = ST_CAPT;
      ST_CAPT:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Macro clocks are registered so they are glitch free; an invalid chip id
  // gives an empty chip_sel and therefore no pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      sram_clk <= '0;
    end else begin
      state    <= state_next;
      sram_clk <= (state_next == ST_CLK_HI) ? chip_sel : '0;
    end
  end

  assign idle = (state == ST_IDLE);
  assign capt = (state == ST_CAPT) && (|chip_sel);

endmodule

// File: rtl/openram_testchip_ctrl.sv
// OpenRAM test-chip controller top: packet register (LA parallel or GPIO
// serial load), per-macro connection muxes and captured read data.
module openram_testchip_ctrl
  import openram_tc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_select,
  input  logic              la_in_load,
  input  logic [PKT_W-1:0]  la_bits,
  input  logic              la_sram_load,
  input  logic              gpio_scan,
  input  logic              gpio_bit,
  input  logic              gpio_sram_load,
  input  logic [DATA_W-1:0] sram0_rw_in,
  input  logic [DATA_W-1:0] sram0_ro_in,
  input  logic [DATA_W-1:0] sram1_rw_in,
  input  logic [DATA_W-1:0] sram1_ro_in,
  input  logic [DATA_W-1:0] sram2_rw_in,
  input  logic [DATA_W-1:0] sram3_rw_in,
  input  logic [DATA_W-1:0] sram4_rw_in,
  output logic [54:0]       sram0_connections,
  output logic [54:0]       sram1_connections,
  output logic [47:0]       sram2_connections,
  output logic [45:0]       sram3_connections,
  output logic [46:0]       sram4_connections,
  output logic              sram0_clk,
  output logic              sram1_clk,
  output logic              sram2_clk,
  output logic              sram3_clk,
  output logic              sram4_clk,
  output logic [DATA_W-1:0] la_data0,
  output logic [DATA_W-1:0] la_data1,
  output logic              gpio_data0,
  output logic              gpio_data1
);

  pkt_t              pkt;
  logic [DATA_W-1:0] data0, data1;
  logic [DATA_W-1:0] port0_dout, port1_dout;
  logic [NSRAM-1:0]  chip_sel;
  logic [NSRAM-1:0]  sram_clk;
  logic [NSRAM-1:0]  csb0_m;
  logic [1:0]        csb1_m;
  logic              go, capt, idle, scan_en;
  seq_state_e        seq_state;

  assign go      = in_select ? gpio_sram_load : la_sram_load;
  assign scan_en = in_select && gpio_scan && idle;

  always_comb begin
    chip_sel = '0;
    for (int i = 0; i < NSRAM; i++) chip_sel[i] = (pkt.chip == CHIP_W'(i));
  end

  openram_tc_seq u_seq (
    .clk      (clk),
    .rst      (reset),
    .go       (go),
    .chip_sel (chip_sel),
    .sram_clk (sram_clk),
    .capt     (capt),
    .idle     (idle),
    .state    (seq_state)
  );

  // The packet is frozen during an op so the macro inputs stay stable
  // around its clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt <= '0;
    end else if (idle) begin
      if (!in_select && la_in_load) pkt <= la_bits;
      else if (scan_en)             pkt <= {pkt[PKT_W-2:0], gpio_bit};
    end
  end

  always_comb begin
    port0_dout = '0;
    port1_dout = '0;
    unique case (pkt.chip)
      CHIP_SRAM0: begin port0_dout = sram0_rw_in; port1_dout = sram0_ro_in; end
      CHIP_SRAM1: begin port0_dout = sram1_rw_in; port1_dout = sram1_ro_in; end
      CHIP_SRAM2: port0_dout = sram2_rw_in;
      CHIP_SRAM3: port0_dout = sram3_rw_in;
      CHIP_SRAM4: port0_dout = sram4_rw_in;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data0 <= '0;
      data1 <= '0;
    end else if (capt) begin
      data0 <= port0_dout;
      data1 <= port1_dout;
    end else if (scan_en) begin
      data0 <= {data0[DATA_W-2:0], 1'b0};
      data1 <= {data1[DATA_W-2:0], 1'b0};
    end
  end

  // Unselected macros keep their chip selects high; other nets follow the packet.
  assign csb0_m = {NSRAM{pkt.csb0}} | ~chip_sel;
  assign csb1_m = {2{pkt.csb1}} | ~chip_sel[1:0];

  assign sram0_connections = {csb0_m[0], pkt.web0, pkt.wmask0, pkt.addr0[7:0], pkt.din0,
                              csb1_m[0], pkt.addr1[7:0]};
  assign sram1_connections = {csb0_m[1], pkt.web0, pkt.wmask0, pkt.addr0[7:0], pkt.din0,
                              csb1_m[1], pkt.addr1[7:0]};
  assign sram2_connections = {csb0_m[2], pkt.web0, pkt.wmask0, pkt.addr0[9:0], pkt.din0};
  assign sram3_connections = {csb0_m[3], pkt.web0, pkt.wmask0, pkt.addr0[7:0], pkt.din0};
  assign sram4_connections = {csb0_m[4], pkt.web0, pkt.wmask0, pkt.addr0[8:0], pkt.din0};

  assign {sram4_clk, sram3_clk, sram2_clk, sram1_clk, sram0_clk} = sram_clk;

  assign la_data0   = data0;
  assign la_data1   = data1;
  assign gpio_data0 = data0[DATA_W-1];
  assign gpio_data1 = data1[DATA_W-1];

  // Port 1 is read-only and macro address widths are narrower than the packet fields.
  logic unused_bits;
  assign unused_bits = ^{pkt.din1, pkt.web1, pkt.wmask1, pkt.addr0[15:10], pkt.addr1[15:8],
                         seq_state};

endmodule

// File: tb/tb_openram_testchip_ctrl.sv
// Bench for openram_testchip_ctrl: behavioural SRAM macros around the DUT, a
// transaction-level expected model and a per-cycle compare process.
module tb_openram_testchip_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_select, la_in_load, la_sram_load, gpio_scan, gpio_bit, gpio_sram_load;
  logic [111:0] la_bits;
  logic [31:0]  rw0, rw1, rw2, rw3, rw4, ro0, ro1;
  logic [54:0]  sram0_connections, sram1_connections;
  logic [47:0]  sram2_connections;
  logic [45:0]  sram3_connections;
  logic [46:0]  sram4_connections;
  logic         sram0_clk, sram1_clk, sram2_clk, sram3_clk, sram4_clk;
  logic [31:0]  la_data0, la_data1;
  logic         gpio_data0, gpio_data1;

  // expected-side state
  logic [31:0]  gold [5][1024];
  logic [31:0]  env_mem [5][1024];
  logic [31:0]  m_dout0 [5];
  logic [31:0]  m_dout1 [2];
  logic [31:0]  exp_d0, exp_d1;
  logic [4:0]   exp_clk;
  logic [111:0] cur_pkt;
  logic [0:0]   exp_q[$];
  int           errors = 0;
  int           checks = 0;
  int           pulse_cnt = 0;

  always #5 clk = ~clk;

  openram_testchip_ctrl dut (
    .clk(clk), .reset(reset), .in_select(in_select), .la_in_load(la_in_load),
    .la_bits(la_bits), .la_sram_load(la_sram_load), .gpio_scan(gpio_scan),
    .gpio_bit(gpio_bit), .gpio_sram_load(gpio_sram_load),
    .sram0_rw_in(rw0), .sram0_ro_in(ro0), .sram1_rw_in(rw1), .sram1_ro_in(ro1),
    .sram2_rw_in(rw2), .sram3_rw_in(rw3), .sram4_rw_in(rw4),
    .sram0_connections(sram0_connections), .sram1_connections(sram1_connections),
    .sram2_connections(sram2_connections), .sram3_connections(sram3_connections),
    .sram4_connections(sram4_connections),
    .sram0_clk(sram0_clk), .sram1_clk(sram1_clk), .sram2_clk(sram2_clk),
    .sram3_clk(sram3_clk), .sram4_clk(sram4_clk),
    .la_data0(la_data0), .la_data1(la_data1),
    .gpio_data0(gpio_data0), .gpio_data1(gpio_data1)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] wm);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (wm[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  function automatic logic [111:0] mk_pkt(input logic [3:0] chip, input logic [15:0] a0,
                                          input logic [31:0] d0, input logic csb0,
                                          input logic web0, input logic [3:0] wm,
                                          input logic [15:0] a1, input logic csb1);
    return {chip, a0, d0, csb0, web0, wm, a1, 32'h0, csb1, 1'b1, 4'h0};
  endfunction

  // What each macro's connection bus must carry for a given packet.
  function automatic logic [63:0] exp_conn(input int m, input logic [111:0] p);
    logic [3:0]  mm;
    logic        c0, c1, w;
    logic [15:0] a0, a1;
    logic [31:0] d0;
    logic [3:0]  wm;
    mm = 4'(m);
    a0 = p[107:92]; d0 = p[91:60]; w = p[58]; wm = p[57:54]; a1 = p[53:38];
    c0 = p[59] | (p[111:108] != mm);
    c1 = p[5]  | (p[111:108] != mm);
    case (m)
      0, 1:    return {9'b0,  c0, w, wm, a0[7:0], d0, c1, a1[7:0]};
      2:       return {16'b0, c0, w, wm, a0[9:0], d0};
      3:       return {18'b0, c0, w, wm, a0[7:0], d0};
      default: return {17'b0, c0, w, wm, a0[8:0], d0};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural macros: dout changes only on a read, holds otherwise.
  always @(posedge sram0_clk) begin
    if (!sram0_connections[8]) ro0 = env_mem[0][{2'b0, sram0_connections[7:0]}];
    if (!sram0_connections[54]) begin
      if (sram0_connections[53]) rw0 = env_mem[0][{2'b0, sram0_connections[48:41]}];
      else env_mem[0][{2'b0, sram0_connections[48:41]}] =
        merge(env_mem[0][{2'b0, sram0_connections[48:41]}], sram0_connections[40:9],
              sram0_connections[52:49]);
    end
  end
  always @(posedge sram1_clk) begin
    if (!sram1_connections[8]) ro1 = env_mem[1][{2'b0, sram1_connections[7:0]}];
    if (!sram1_connections[54]) begin
      if (sram1_connections[53]) rw1 = env_mem[1][{2'b0, sram1_connections[48:41]}];
      else env_mem[1][{2'b0, sram1_connections[48:41]}] =
        merge(env_mem[1][{2'b0, sram1_connections[48:41]}], sram1_connections[40:9],
              sram1_connections[52:49]);
    end
  end
  always @(posedge sram2_clk) begin
    if (!sram2_connections[47]) begin
      if (sram2_connections[46]) rw2 = env_mem[2][sram2_connections[41:32]];
      else env_mem[2][sram2_connections[41:32]] =
        merge(env_mem[2][sram2_connections[41:32]], sram2_connections[31:0],
              sram2_connections[45:42]);
    end
  end
  always @(posedge sram3_clk) begin
    if (!sram3_connections[45]) begin
      if (sram3_connections[44]) rw3 = env_mem[3][{2'b0, sram3_connections[39:32]}];
      else env_mem[3][{2'b0, sram3_connections[39:32]}] =
        merge(env_mem[3][{2'b0, sram3_connections[39:32]}], sram3_connections[31:0],
              sram3_connections[43:40]);
    end
  end
  always @(posedge sram4_clk) begin
    if (!sram4_connections[46]) begin
      if (sram4_connections[45]) rw4 = env_mem[4][{1'b0, sram4_connections[40:32]}];
      else env_mem[4][{1'b0, sram4_connections[40:32]}] =
        merge(env_mem[4][{1'b0, sram4_connections[40:32]}], sram4_connections[31:0],
              sram4_connections[44:41]);
    end
  end

  // Compare process: every output checked against the model on each falling edge.
  always @(negedge clk) begin
    logic [4:0] clks;
    clks = {sram4_clk, sram3_clk, sram2_clk, sram1_clk, sram0_clk};
    check("la_data0",   64'(la_data0),   64'(exp_d0));
    check("la_data1",   64'(la_data1),   64'(exp_d1));
    check("gpio_data0", 64'(gpio_data0), 64'(exp_d0[31]));
    check("gpio_data1", 64'(gpio_data1), 64'(exp_d1[31]));
    check("sram_clk",   64'(clks),       64'(exp_clk));
    check("conn0", 64'(sram0_connections), exp_conn(0, cur_pkt));
    check("conn1", 64'(sram1_connections), exp_conn(1, cur_pkt));
    check("conn2", 64'(sram2_connections), exp_conn(2, cur_pkt));
    check("conn3", 64'(sram3_connections), exp_conn(3, cur_pkt));
    check("conn4", 64'(sram4_connections), exp_conn(4, cur_pkt));
    if (|clks) pulse_cnt++;
  end

  // Transaction-level effect of one op on the golden memories and read ports.
  task automatic model_apply(input logic [111:0] p, output logic upd,
                             output logic [31:0] d0, output logic [31:0] d1);
    logic [3:0] c;
    logic [9:0] amask, a0, a1;
    c = p[111:108];
    upd = 1'b0; d0 = exp_d0; d1 = exp_d1;
    if (c < 4'd5) begin
      amask = (c == 4'd2) ? 10'h3FF : (c == 4'd4) ? 10'h1FF : 10'h0FF;
      a0 = p[101:92] & amask;
      a1 = p[47:38] & amask;
      if (c < 4'd2 && !p[5]) m_dout1[c[0]] = gold[c][a1];
      if (!p[59]) begin
        if (p[58]) m_dout0[c] = gold[c][a0];
        else gold[c][a0] = merge(gold[c][a0], p[91:60], p[57:54]);
      end
      upd = 1'b1;
      d0  = m_dout0[c];
      d1  = (c < 4'd2) ? m_dout1[c[0]] : 32'h0;
    end
  endtask

  // Driver tasks start and end 1 time unit after a rising edge.
  task automatic la_load(input logic [111:0] p);
    la_bits = p; la_in_load = 1'b1;
    @(posedge clk); #1;
    la_in_load = 1'b0; cur_pkt = p;
  endtask

  task automatic scan(input logic b);
    gpio_bit = b; gpio_scan = 1'b1;
    @(posedge clk); #1;
    gpio_scan = 1'b0;
    cur_pkt = {cur_pkt[110:0], b};
    exp_d0  = {exp_d0[30:0], 1'b0};
    exp_d1  = {exp_d1[30:0], 1'b0};
  endtask

  task automatic do_op();
    logic        upd;
    logic [31:0] d0, d1;
    logic [3:0]  c;
    c = cur_pkt[111:108];
    if (in_select) gpio_sram_load = 1'b1; else la_sram_load = 1'b1;
    @(posedge clk); #1;
    gpio_sram_load = 1'b0; la_sram_load = 1'b0;
    model_apply(cur_pkt, upd, d0, d1);
    if (c < 4'd5) exp_clk = 5'b1 << c;
    @(posedge clk); #1; exp_clk = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (upd) begin exp_d0 = d0; exp_d1 = d1; end
  endtask

  initial begin
    logic        upd;
    logic [31:0] d0, d1, got;
    logic [111:0] p;
    int          pc;
    reset = 1'b1; in_select = 1'b0; la_in_load = 1'b0; la_sram_load = 1'b0;
    gpio_scan = 1'b0; gpio_bit = 1'b0; gpio_sram_load = 1'b0; la_bits = '0;
    rw0 = '0; rw1 = '0; rw2 = '0; rw3 = '0; rw4 = '0; ro0 = '0; ro1 = '0;
    cur_pkt = '0; exp_d0 = '0; exp_d1 = '0; exp_clk = '0;
    for (int m = 0; m < 5; m++) begin
      m_dout0[m] = '0;
      for (int a = 0; a < 1024; a++) begin gold[m][a] = '0; env_mem[m][a] = '0; end
    end
    m_dout1[0] = '0; m_dout1[1] = '0;

    repeat (3) @(posedge clk); #1;
    check("rst_la_data0", 64'(la_data0), 64'h0);
    check("rst_la_data1", 64'(la_data1), 64'h0);
    check("rst_clks", 64'({sram4_clk, sram3_clk, sram2_clk, sram1_clk, sram0_clk}), 64'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: chip0 write then read back
    la_load(mk_pkt(4'd0, 16'h1, 32'h1, 1'b0, 1'b0, 4'hF, 16'h0, 1'b1));
    pc = pulse_cnt;
    do_op();
    check("t1_one_pulse", 64'(pulse_cnt - pc), 64'd1);
    la_load(mk_pkt(4'd0, 16'h1, 32'h0, 1'b0, 1'b1, 4'hF, 16'h0, 1'b1));
    do_op();
    check("t1_read", 64'(la_data0), 64'h1);

    // 2: port 1 read of the same word
    la_load(mk_pkt(4'd0, 16'h0, 32'h0, 1'b1, 1'b1, 4'h0, 16'h1, 1'b0));
    do_op();
    check("t2_port1", 64'(la_data1), 64'h1);

    // 3: chip2 top address, byte-masked write through a truncated address
    la_load(mk_pkt(4'd2, 16'h03FF, 32'h12345678, 1'b0, 1'b0, 4'hF, 16'h0, 1'b1));
    do_op();
    la_load(mk_pkt(4'd2, 16'hFFFF, 32'hDEADBEEF, 1'b0, 1'b0, 4'b0011, 16'h0, 1'b1));
    check("t3_conn2", 64'(sram2_connections), {16'h0, 1'b0, 1'b0, 4'b0011, 10'h3FF, 32'hDEADBEEF});
    check("t3_csb_forced", 64'({sram0_connections[54], sram0_connections[8]}), 64'h3);
    do_op();
    la_load(mk_pkt(4'd2, 16'h03FF, 32'h0, 1'b0, 1'b1, 4'hF, 16'h0, 1'b1));
    do_op();
    check("t3_masked", 64'(la_data0), 64'h1234BEEF);

    // 5: invalid chip id, no strobe, data held
    la_load(mk_pkt(4'd7, 16'h1, 32'h0, 1'b0, 1'b1, 4'hF, 16'h1, 1'b0));
    pc = pulse_cnt;
    do_op();
    check("t5_no_strobe", 64'(pulse_cnt - pc), 64'd0);
    check("t5_hold", 64'(la_data0), 64'h1234BEEF);

    // 4: GPIO path, chip3 read shifted out MSB first
    la_load(mk_pkt(4'd3, 16'h5A, 32'hA5C30F96, 1'b0, 1'b0, 4'hF, 16'h0, 1'b1));
    do_op();
    in_select = 1'b1;
    p = mk_pkt(4'd3, 16'h5A, 32'h0, 1'b0, 1'b1, 4'hF, 16'h0, 1'b1);
    for (int i = 111; i >= 0; i--) scan(p[i]);
    do_op();
    d0 = 32'hA5C30F96;
    for (int i = 31; i >= 0; i--) exp_q.push_back(d0[i]);
    got = '0;
    for (int i = 0; i < 32; i++) begin
      got = {got[30:0], gpio_data0};
      check("t4_bit", 64'(gpio_data0), 64'(exp_q.pop_front()));
      scan(1'b0);
    end
    check("t4_word", 64'(got), 64'hA5C30F96);
    in_select = 1'b0;

    // 6: reset while the macro clock is high
    p = mk_pkt(4'd0, 16'h1, 32'h0, 1'b0, 1'b1, 4'hF, 16'h0, 1'b1);
    la_load(p);
    la_sram_load = 1'b1;
    @(posedge clk); #1;
    la_sram_load = 1'b0;
    model_apply(cur_pkt, upd, d0, d1);
    exp_clk = 5'b00001;
    #2;
    reset = 1'b1;
    exp_clk = '0; exp_d0 = '0; exp_d1 = '0; cur_pkt = '0;
    #1;
    check("t6_clk_low", 64'(sram0_clk), 64'h0);
    check("t6_data_clr", 64'(la_data0), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    la_load(p);
    do_op();
    check("t6_after", 64'(la_data0), 64'h1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
